// File: rtl/sram_bus_pkg.sv
// Shared constants for the data-SRAM-like request/response bus.
// Used by both the memory model slave and the future AXI bridge.
package sram_bus_pkg;

    localparam int SRAM_ADDR_WD = 32;
    localparam int SRAM_DATA_WD = 32;
    localparam int SRAM_WEN_WD  = 4;

    // A queued response only carries read data; writes answer with zero.
    localparam int SRAM_RESP_WD = SRAM_DATA_WD;

endpackage : sram_bus_pkg

// File: rtl/resp_fifo.sv
// In-order response queue: circular buffer whose pointers wrap at DEPTH,
// so depths that are not a power of two are supported.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Entry storage is not reset; an empty queue never exposes it.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[tail_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= wrap_inc(tail_ptr);
            end
            if (pop) begin
                head_ptr <= wrap_inc(head_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = slots[head_ptr];

endmodule : resp_fifo

// File: rtl/data_sram_slave.sv
// Responder for the data-SRAM-like bus: word memory with byte-enabled writes,
// bounded outstanding requests and in-order responses after a fixed head delay.
module data_sram_slave
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int OUTSTANDING = 2,
    parameter int RESP_DELAY  = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    data_sram_req,
    input  logic                    data_sram_wr,
    input  logic [SRAM_WEN_WD-1:0]  data_sram_wen,
    input  logic [SRAM_ADDR_WD-1:0] data_sram_addr,
    input  logic [SRAM_DATA_WD-1:0] data_sram_wdata,
    input  logic                    stall_inject,
    output logic                    data_sram_addr_ok,
    output logic                    data_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0] data_sram_rdata
);

    localparam int CNT_W       = $clog2(OUTSTANDING + 1);
    localparam int WAIT_W      = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
    localparam int DEPTH_WORDS = 1 << ADDR_W;

    logic [SRAM_DATA_WD-1:0] mem [DEPTH_WORDS];
    logic [ADDR_W-1:0]       word_idx;
    logic                    accept;
    logic                    resp_pop;
    logic [CNT_W-1:0]        count;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [SRAM_RESP_WD-1:0] push_data;
    logic [SRAM_RESP_WD-1:0] head_data;
    logic                    unused_addr_bits;

    assign word_idx         = data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{data_sram_addr[SRAM_ADDR_WD-1:ADDR_W+2], data_sram_addr[1:0]};

    // Full is judged on the registered count only, so a same-cycle pop does not free a slot.
    assign data_sram_addr_ok = resetn && data_sram_req && !stall_inject
                               && (count < CNT_W'(OUTSTANDING));
    assign accept            = data_sram_req && data_sram_addr_ok;

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int lane = 0; lane < SRAM_WEN_WD; lane++) begin
                if (data_sram_wen[lane]) begin
                    mem[word_idx][8*lane +: 8] <= data_sram_wdata[8*lane +: 8];
                end
            end
        end
    end

    // Reads capture the pre-edge word; writes queue a zero response.
    assign push_data = data_sram_wr ? '0 : mem[word_idx];

    resp_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (SRAM_RESP_WD)
    ) u_resp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (resp_pop),
        .din    (push_data),
        .dout   (head_data),
        .count  (count)
    );

    assign data_sram_data_ok = (count != '0) && (wait_cnt == WAIT_W'(RESP_DELAY));
    assign resp_pop          = data_sram_data_ok;
    assign data_sram_rdata   = (count != '0) ? head_data : '0;

    // Cycles the current head has waited; restarts for each new head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (resp_pop || (count == '0)) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(RESP_DELAY)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule : data_sram_slave

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: a fast instance (no delay) and a slow instance
// (delay 3), checked every cycle against a queue/timestamp model of the bus.
module tb_data_sram_slave;

    localparam int ADDR_W = 12;
    localparam int OUT_A  = 2;
    localparam int DLY_A  = 0;
    localparam int OUT_B  = 2;
    localparam int DLY_B  = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_a, wr_a, stall_a, ok_a, dok_a;
    logic [3:0]  wen_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, wr_b, stall_b, ok_b, dok_b;
    logic [3:0]  wen_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    always #5 clk = ~clk;

    data_sram_slave #(.ADDR_W(ADDR_W), .OUTSTANDING(OUT_A), .RESP_DELAY(DLY_A)) dut_a (
        .clk (clk), .resetn (resetn),
        .data_sram_req (req_a), .data_sram_wr (wr_a), .data_sram_wen (wen_a),
        .data_sram_addr (addr_a), .data_sram_wdata (wdata_a), .stall_inject (stall_a),
        .data_sram_addr_ok (ok_a), .data_sram_data_ok (dok_a), .data_sram_rdata (rdata_a)
    );

    data_sram_slave #(.ADDR_W(ADDR_W), .OUTSTANDING(OUT_B), .RESP_DELAY(DLY_B)) dut_b (
        .clk (clk), .resetn (resetn),
        .data_sram_req (req_b), .data_sram_wr (wr_b), .data_sram_wen (wen_b),
        .data_sram_addr (addr_b), .data_sram_wdata (wdata_b), .stall_inject (stall_b),
        .data_sram_addr_ok (ok_b), .data_sram_data_ok (dok_b), .data_sram_rdata (rdata_b)
    );

    // A pending response: the cycle it is due and the data it must carry.
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        bit          known;
    } entry_t;

    entry_t      model_q[$];
    logic [31:0] mem_val[int];
    logic [3:0]  mem_known[int];
    int          last_due[2];
    int          cyc = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          acc_a[$], dok_log_a[$], acc_b[$], dok_log_b[$];
    logic [31:0] rd_a[$], rd_b[$];

    function automatic int out_of(input int inst);
        return (inst == 0) ? OUT_A : OUT_B;
    endfunction

    function automatic int delay_of(input int inst);
        return (inst == 0) ? DLY_A : DLY_B;
    endfunction

    function automatic int inst_count(input int inst);
        int n = 0;
        foreach (model_q[k]) if (model_q[k].inst == inst) n++;
        return n;
    endfunction

    function automatic int head_idx(input int inst);
        for (int k = 0; k < model_q.size(); k++) if (model_q[k].inst == inst) return k;
        return -1;
    endfunction

    task automatic get_inputs(input int inst, output bit r, output bit w, output logic [3:0] we,
                              output logic [31:0] ad, output logic [31:0] wd, output bit st);
        if (inst == 0) begin
            r = req_a; w = wr_a; we = wen_a; ad = addr_a; wd = wdata_a; st = stall_a;
        end else begin
            r = req_b; w = wr_b; we = wen_b; ad = addr_b; wd = wdata_b; st = stall_b;
        end
    endtask

    task automatic set_inputs(input int inst, input bit r, input bit w, input logic [3:0] we,
                              input logic [31:0] ad, input logic [31:0] wd);
        if (inst == 0) begin
            req_a = r; wr_a = w; wen_a = we; addr_a = ad; wdata_a = wd;
        end else begin
            req_b = r; wr_b = w; wen_b = we; addr_b = ad; wdata_b = wd;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Model: a response is due D cycles after it becomes head; it becomes head
    // the cycle after its accept or the cycle after the previous response.
    always @(posedge clk) begin
        if (!resetn) begin
            model_q.delete();
            last_due[0] = -1000;
            last_due[1] = -1000;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit          r, w, st;
                logic [3:0]  we;
                logic [31:0] ad, wd, v;
                logic [3:0]  kn;
                entry_t      e;
                int          key;
                get_inputs(i, r, w, we, ad, wd, st);
                if (r && !st && inst_count(i) < out_of(i)) begin
                    key = i * 65536 + int'(ad[ADDR_W+1:2]);
                    if (!mem_val.exists(key)) begin
                        mem_val[key]   = 32'h0;
                        mem_known[key] = 4'h0;
                    end
                    e.inst = i;
                    e.due  = (((cyc + 1) > (last_due[i] + 1)) ? (cyc + 1) : (last_due[i] + 1)) + delay_of(i);
                    last_due[i] = e.due;
                    if (w) begin
                        v  = mem_val[key];
                        kn = mem_known[key];
                        for (int b = 0; b < 4; b++) begin
                            if (we[b]) begin
                                v[8*b +: 8] = wd[8*b +: 8];
                                kn[b] = 1'b1;
                            end
                        end
                        mem_val[key]   = v;
                        mem_known[key] = kn;
                        e.data  = 32'h0;
                        e.known = 1'b1;
                    end else begin
                        e.data  = mem_val[key];
                        e.known = (mem_known[key] == 4'hF);
                    end
                    model_q.push_back(e);
                end
            end
            for (int j = model_q.size() - 1; j >= 0; j--) begin
                if (model_q[j].due <= cyc) model_q.delete(j);
            end
        end
        cyc = cyc + 1;
    end

    // Compare every cycle on the falling edge, and log what the DUTs did.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          r, w, st, e_ok, e_dok;
            logic [3:0]  we;
            logic [31:0] ad, wd, act_rd;
            logic        act_ok, act_dok;
            int          h;
            get_inputs(i, r, w, we, ad, wd, st);
            act_ok  = (i == 0) ? ok_a : ok_b;
            act_dok = (i == 0) ? dok_a : dok_b;
            act_rd  = (i == 0) ? rdata_a : rdata_b;
            h       = head_idx(i);
            e_ok    = resetn && r && !st && (inst_count(i) < out_of(i));
            e_dok   = resetn && (h >= 0) && (model_q[h].due == cyc);
            check_output((i == 0) ? "addr_ok_a" : "addr_ok_b", 32'(act_ok), 32'(e_ok));
            check_output((i == 0) ? "data_ok_a" : "data_ok_b", 32'(act_dok), 32'(e_dok));
            if (!resetn) begin
                check_output((i == 0) ? "rdata_reset_a" : "rdata_reset_b", act_rd, 32'h0);
            end else if (e_dok && model_q[h].known) begin
                check_output((i == 0) ? "rdata_a" : "rdata_b", act_rd, model_q[h].data);
            end
            if (i == 0) begin
                if (resetn && r && act_ok) acc_a.push_back(cyc);
                if (act_dok) begin dok_log_a.push_back(cyc); rd_a.push_back(act_rd); end
            end else begin
                if (resetn && r && act_ok) acc_b.push_back(cyc);
                if (act_dok) begin dok_log_b.push_back(cyc); rd_b.push_back(act_rd); end
            end
        end
    end

    task automatic clear_logs();
        acc_a.delete(); dok_log_a.delete(); rd_a.delete();
        acc_b.delete(); dok_log_b.delete(); rd_b.delete();
    endtask

    // Hold a request until it is accepted; entered and left just after a rising edge.
    task automatic issue(input int inst, input bit w, input logic [3:0] we,
                         input logic [31:0] ad, input logic [31:0] wd);
        bit got = 1'b0;
        set_inputs(inst, 1'b1, w, we, ad, wd);
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = (inst == 0) ? ok_a : ok_b;
            @(posedge clk);
            #1;
        end
        set_inputs(inst, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (!got) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout inst %0d addr 0x%08h: got no addr_ok, expected one", inst, ad);
        end
    endtask

    task automatic wait_resp(input int inst, input int n);
        int k = 0;
        while (((inst == 0) ? dok_log_a.size() : dok_log_b.size()) < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (((inst == 0) ? dok_log_a.size() : dok_log_b.size()) < n) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL resp_timeout inst %0d: got %0d responses, expected %0d", inst,
                     (inst == 0) ? dok_log_a.size() : dok_log_b.size(), n);
        end
    endtask

    task automatic apply_stimulus();
        int stall_low;
        int a0;

        // Reset state, with a request held high to show addr_ok is gated.
        resetn = 1'b0;
        set_inputs(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_inputs(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        stall_a = 1'b0;
        stall_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_a = 1'b1;
        #1;
        check_output("reset_addr_ok_a", 32'(ok_a), 32'h0);
        check_output("reset_data_ok_a", 32'(dok_a), 32'h0);
        check_output("reset_rdata_a", rdata_a, 32'h0);
        check_output("reset_data_ok_b", 32'(dok_b), 32'h0);
        req_a = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("[TB] write then read");
        clear_logs();
        issue(0, 1'b1, 4'hF, 32'h100, 32'h12345678);
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
        wait_resp(0, 2);
        check_output("wr_rd_count", 32'(rd_a.size()), 32'd2);
        if (rd_a.size() >= 2) begin
            check_output("wr_rd_write_resp", rd_a[0], 32'h0);
            check_output("wr_rd_read_data", rd_a[1], 32'h12345678);
        end

        $display("[TB] byte enables");
        clear_logs();
        issue(0, 1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
        issue(0, 1'b1, 4'b0100, 32'h40, 32'h00AB0000);
        issue(0, 1'b0, 4'h0, 32'h40, 32'h0);
        issue(0, 1'b1, 4'h0, 32'h40, 32'h12121212);
        issue(0, 1'b0, 4'h0, 32'h40, 32'h0);
        wait_resp(0, 5);
        if (rd_a.size() >= 5) begin
            check_output("byte_lane_merge", rd_a[2], 32'hFFABFFFF);
            check_output("wen_zero_no_change", rd_a[4], 32'hFFABFFFF);
        end

        $display("[TB] stall inject");
        clear_logs();
        stall_low = 0;
        set_inputs(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        stall_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!ok_a) stall_low++;
            @(posedge clk);
            #1;
        end
        stall_a = 1'b0;
        issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
        wait_resp(0, 1);
        check_output("stall_low_cycles", 32'(stall_low), 32'd5);
        if (rd_a.size() >= 1) check_output("stall_read_data", rd_a[0], 32'h12345678);

        $display("[TB] streaming reads");
        for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'hF, 32'(4 * i), 32'hA0000000 + 32'(i));
        wait_resp(0, 9);
        clear_logs();
        for (int i = 0; i < 8; i++) issue(0, 1'b0, 4'h0, 32'(4 * i), 32'h0);
        wait_resp(0, 8);
        check_output("stream_accepts", 32'(acc_a.size()), 32'd8);
        if (acc_a.size() == 8 && dok_log_a.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_output("stream_accept_cycle", 32'(acc_a[i] - acc_a[0]), 32'(i));
                check_output("stream_resp_cycle", 32'(dok_log_a[i] - acc_a[0]), 32'(i + 1));
                check_output("stream_data", rd_a[i], 32'hA0000000 + 32'(i));
            end
        end

        $display("[TB] backpressure on slow instance");
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'hF, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i));
        wait_resp(1, 4);
        clear_logs();
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'h0, 32'h200 + 32'(4 * i), 32'h0);
        wait_resp(1, 4);
        if (acc_b.size() == 4 && dok_log_b.size() == 4) begin
            a0 = acc_b[0];
            check_output("bp_accept1", 32'(acc_b[1] - a0), 32'd1);
            check_output("bp_accept2", 32'(acc_b[2] - a0), 32'd5);
            check_output("bp_accept3", 32'(acc_b[3] - a0), 32'd9);
            check_output("bp_resp0", 32'(dok_log_b[0] - a0), 32'd4);
            check_output("bp_resp1", 32'(dok_log_b[1] - a0), 32'd8);
            check_output("bp_resp2", 32'(dok_log_b[2] - a0), 32'd12);
            check_output("bp_resp3", 32'(dok_log_b[3] - a0), 32'd16);
            for (int i = 0; i < 4; i++) check_output("bp_data", rd_b[i], 32'hB0000000 + 32'(i));
        end else begin
            check_output("bp_log_sizes", 32'(acc_b.size() * 16 + dok_log_b.size()), 32'h44);
        end

        $display("[TB] reset with requests outstanding");
        issue(1, 1'b1, 4'hF, 32'h300, 32'hCAFEF00D);
        wait_resp(1, 1);
        clear_logs();
        issue(1, 1'b0, 4'h0, 32'h300, 32'h0);
        issue(1, 1'b0, 4'h0, 32'h200, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_output("pre_reset_data_ok_b", 32'(dok_b), 32'h1);
        resetn = 1'b0;
        set_inputs(1, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        #1;
        check_output("mid_reset_data_ok_b", 32'(dok_b), 32'h0);
        check_output("mid_reset_addr_ok_b", 32'(ok_b), 32'h0);
        check_output("mid_reset_rdata_b", rdata_b, 32'h0);
        clear_logs();
        @(posedge clk);
        @(posedge clk);
        #1;
        set_inputs(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_output("no_stale_resp", 32'(dok_log_b.size()), 32'h0);
        issue(1, 1'b0, 4'h0, 32'h300, 32'h0);
        wait_resp(1, 1);
        if (rd_b.size() >= 1) check_output("mem_survives_reset", rd_b[0], 32'hCAFEF00D);
    endtask

    initial begin
        apply_stimulus();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected one before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_data_sram_slave

// File: doc/data_sram_slave.md
# data_sram_slave

Responder end of the data-SRAM-like bus driven by the execute stage's `data_sram_*` request port. It accepts `req`/`addr_ok` handshakes, performs byte-enabled writes and word reads on an internal word-addressed memory, and returns one in-order `data_ok` response per accepted request. Backpressure and response delay are configurable. It serves as the data-side memory model for core-level simulation and as the slave template for the later AXI bridge.

## Interface
- `ADDR_W`, 12: word-address bits used; memory holds 2^ADDR_W 32-bit words, indexed by `data_sram_addr[ADDR_W+1:2]`.
- `OUTSTANDING`, 2: maximum accepted-but-unanswered requests (≥1).
- `RESP_DELAY`, 0: extra cycles a request waits at queue head before `data_ok`.

- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_sram_req`  in  1  request valid.
- `data_sram_wr`  in  1  1 = write, 0 = read.
- `data_sram_wen`  in  4  byte enables for writes; ignored for reads.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, byte lanes aligned to `wen`.
- `stall_inject`  in  1  testbench backpressure; 1 forces `addr_ok` low.
- `data_sram_addr_ok`  out  1  request accepted this cycle.
- `data_sram_data_ok`  out  1  head response valid this cycle.
- `data_sram_rdata`  out  32  read data for the head response; 0 for write responses.

## Operation
- `addr_ok = resetn && req && !stall_inject && (count < OUTSTANDING)`. Full is judged on the current count only. A pop in the same cycle does not free a slot.
- Accept (`req && addr_ok` at clk edge):
  - Write: each lane i with `wen[i]` updates the byte at that edge; other bytes are untouched. Queue entry stores `rdata = 0`.
  - Read: entry stores the memory word as it was before this edge. This is the read-before-write view of the same cycle, which cannot occur because there is only one request per cycle.
- Order: responses return strictly in acceptance order. A read accepted after a write to the same word returns the written data.
- Response: `wait_cnt` counts cycles the current head has waited. `data_ok = (count != 0) && (wait_cnt == RESP_DELAY)`. `rdata` is the head entry's data, driven combinationally.
- Pop on `data_ok`. The requester is always ready, with no `data_ok` backpressure. On pop or while empty, `wait_cnt` goes to 0. Otherwise it increments, saturating at `RESP_DELAY`.
- Simultaneous push and pop: count is unchanged. The new entry is written at tail while head advances.
- `wen = 0` write: it is accepted and acknowledged, and memory is unchanged.

## Timing
- Reset (async assert, released synchronously by `clk`): count=0, head/tail pointers=0, `wait_cnt`=0, `addr_ok`=0, `data_ok`=0, `rdata`=0. Memory contents are not reset. Requests outstanding at reset are dropped with no response.
- Latency: with `RESP_DELAY=0`, `data_ok` is asserted in the cycle after acceptance, at the earliest. In general it is asserted `1+RESP_DELAY` cycles after acceptance if the request reaches an empty queue.
- Throughput: with `RESP_DELAY=0`, one accept and one response per cycle are sustained. `OUTSTANDING=1` with `RESP_DELAY=0` yields one accept every 2 cycles, because full is judged without a pop bypass.
- `addr_ok` is combinational from `req` and the registered state. `data_ok` and `rdata` depend only on registered state.

## Structure
- Shared package `sram_bus_pkg`:
  - bus width constants (`SRAM_ADDR_WD=32`, `SRAM_DATA_WD=32`, `SRAM_WEN_WD=4`)
  - response entry width (`SRAM_RESP_WD = SRAM_DATA_WD`)
- Sub-module `resp_fifo`:
  - parameterised depth/width, circular buffer with pointer wrap at `OUTSTANDING`
  - ports `push`/`pop`/`din`/`dout`/`count`
- The top level holds the memory array, the accept logic, and `wait_cnt`.

## Test plan
- Write-then-read: write 0x12345678 to 0x100 with `wen=4'hF`, then read 0x100. Expect two `data_ok` pulses in order; second `rdata=0x12345678`.
- Byte enables: preload 0xFFFFFFFF at 0x40, write 0x00AB0000 with `wen=4'b0100`, then read. Expect `rdata=0xFFABFFFF`.
- Backpressure:
  - with `OUTSTANDING=2`, `RESP_DELAY=3`, issue 4 back-to-back reads. Expect `addr_ok` low after 2 accepts until the first `data_ok`, and all 4 responses returned in order.
  - `stall_inject=1` for 5 cycles with `req` high. Expect `addr_ok=0` for those cycles, then acceptance.
- Streaming: with `RESP_DELAY=0`, 8 consecutive reads of 0x0..0x1C. Expect 8 accepts in 8 cycles and `data_ok` high for 8 consecutive cycles starting 1 cycle after the first accept.
- Reset mid-operation: assert `resetn=0` with 2 requests outstanding. Expect `data_ok`/`addr_ok` to go 0 immediately and no stale response after release; a later read of a previously written word still returns its data.
